// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the memory-bus responder: address map, FSM encoding
// and the wait-count selector.
package mem_bus_responder_pkg;

    localparam logic [15:0] MAP_RAM_BASE = 16'h0100;
    localparam int          WAIT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    function automatic logic [WAIT_W-1:0] wait_count(
        input logic              is_write,
        input logic [WAIT_W-1:0] rd_wait,
        input logic [WAIT_W-1:0] wr_wait
    );
        return is_write ? wr_wait : rd_wait;
    endfunction

endpackage

// File: rtl/mem_bus_responder_sp_ram.sv
// Single-port synchronous byte RAM: one write-or-read per enabled cycle.
// Read data is registered and holds until the next enabled read.
module mem_bus_responder_sp_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus target: decodes the RAM window, inserts programmable wait
// states and completes each access with a 4-phase req/ready handshake.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter logic [15:0] RAM_BASE   = MAP_RAM_BASE,
    parameter int          RAM_DEPTH  = 256,
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic [7:0]  rdata_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int                AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [WAIT_W-1:0] RD_WAIT = WAIT_W'(READ_WAIT);
    localparam logic [WAIT_W-1:0] WR_WAIT = WAIT_W'(WRITE_WAIT);

    generate
        if (READ_WAIT < 0 || READ_WAIT > 15 || WRITE_WAIT < 0 || WRITE_WAIT > 15) begin : g_bad_wait
            $error("mem_bus_responder: READ_WAIT/WRITE_WAIT must be in 0..15");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              we_q, we_d;
    logic [AW-1:0]     off_q, off_d;
    logic [7:0]        wdata_q, wdata_d;

    logic [16:0]       diff;
    logic              hit;
    logic              ram_en;
    logic [7:0]        ram_rdata;

    // 17-bit offset keeps windows ending at 16'hFFFF from wrapping around.
    assign diff = {1'b0, addr_i} - {1'b0, RAM_BASE};
    assign hit  = (addr_i >= RAM_BASE) && (diff < 17'(RAM_DEPTH));

    // Gating with reset stops an access aborted on its ACCESS edge from committing.
    assign ram_en = (state_q == ST_ACCESS) && !reset;

    mem_bus_responder_sp_ram #(
        .DEPTH (RAM_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (we_q),
        .addr_i  (off_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        ready_d = ready_q;
        err_d   = err_q;
        busy_d  = busy_q;
        we_d    = we_q;
        off_d   = off_q;
        wdata_d = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    off_d   = diff[AW-1:0];
                    wdata_d = wdata_i;
                    busy_d  = 1'b1;
                    if (!hit) begin
                        err_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = wait_count(we_i, RD_WAIT, WR_WAIT);
                        state_d = (cnt_d != '0) ? ST_WAIT : ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_ACK;
            end
            ST_ACK: begin
                // First ACK cycle raises ready and captures read data; only then may req release it.
                if (!ready_q) begin
                    ready_d = 1'b1;
                    if (!we_q && !err_q) begin
                        rdata_d = ram_rdata;
                    end
                end else if (!req_i) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= 8'h00;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Request latch is pure data; it is only consulted after a fresh acceptance.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        off_q   <= off_d;
        wdata_q <= wdata_d;
    end

    assign rdata_o = rdata_q;
    assign ready_o = ready_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;

endmodule
